// File: rtl/fp32_add_seq_ctrl.sv
// fp32_add_seq_ctrl: multi-cycle binary32 adder/subtractor.
// It accepts one operand pair through a valid/ready handshake and unpacks it.
// A serial shifter aligns the smaller operand one bit per cycle.
// Magnitudes are then added or subtracted and normalized serially.
// The packed result is held behind a valid/ready output handshake.
// Rounding is truncation toward zero, and denormal inputs are flushed to zero.
module fp32_add_seq_ctrl #(
   parameter int GUARD_BITS = 2,
   parameter int MAX_SHIFT  = 26
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        flag_ovf,
   output logic        flag_unf,
   output logic        flag_inv,
   output logic        busy
);

   // Mantissa with hidden bit and guard bits, plus one carry bit for the sum.
   localparam int MAN_W = 24 + GUARD_BITS;
   localparam int SUM_W = MAN_W + 1;
   localparam int CNT_W = $clog2(MAX_SHIFT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_DONE
   } state_t;

   state_t             state_q,   state_d;
   logic               sign_q,    sign_d;
   logic               eff_sub_q, eff_sub_d;
   logic [8:0]         exp_q,     exp_d;
   logic [MAN_W-1:0]   big_q,     big_d;
   logic [MAN_W-1:0]   small_q,   small_d;
   logic [SUM_W-1:0]   mag_q,     mag_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic [31:0]        result_q,  result_d;
   logic               ovf_q,     ovf_d;
   logic               unf_q,     unf_d;
   logic               inv_q,     inv_d;

   // Unpacked view of the incoming operand pair.
   logic               sgn_a, sgn_b;
   logic [7:0]         exp_a, exp_b;
   logic [MAN_W-1:0]   man_a, man_b;
   logic               a_is_big;
   logic [7:0]         exp_diff;
   logic [CNT_W-1:0]   shift_amt;
   logic               any_special;

   // The alignment distance saturates once the whole mantissa has shifted out.
   function automatic logic [CNT_W-1:0] sat_shift(input logic [7:0] d);
      if (32'(d) > MAX_SHIFT) begin
         return CNT_W'(MAX_SHIFT);
      end
      return d[CNT_W-1:0];
   endfunction

   // Exponent overflow saturates the packed result to signed infinity.
   function automatic logic [31:0] pack(input logic s, input logic [8:0] e,
                                        input logic [22:0] f);
      if (e >= 9'd255) begin
         return {s, 8'hFF, 23'd0};
      end
      return {s, e[7:0], f};
   endfunction

   // Unpack operands, flush denormals, order by magnitude and find the shift.
   always_comb begin
      sgn_a       = op_a[31];
      sgn_b       = op_b[31] ^ sub;
      exp_a       = op_a[30:23];
      exp_b       = op_b[30:23];
      man_a       = (exp_a == 8'd0) ? '0 : {1'b1, op_a[22:0], {GUARD_BITS{1'b0}}};
      man_b       = (exp_b == 8'd0) ? '0 : {1'b1, op_b[22:0], {GUARD_BITS{1'b0}}};
      a_is_big    = ({exp_a, man_a} >= {exp_b, man_b});
      exp_diff    = a_is_big ? (exp_a - exp_b) : (exp_b - exp_a);
      shift_amt   = sat_shift(exp_diff);
      any_special = (exp_a == 8'hFF) || (exp_b == 8'hFF);
   end

   // Next-state and datapath updates for the sequencer.
   always_comb begin
      state_d   = state_q;
      sign_d    = sign_q;
      eff_sub_d = eff_sub_q;
      exp_d     = exp_q;
      big_d     = big_q;
      small_d   = small_q;
      mag_d     = mag_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      inv_d     = inv_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               ovf_d     = 1'b0;
               unf_d     = 1'b0;
               inv_d     = 1'b0;
               sign_d    = a_is_big ? sgn_a : sgn_b;
               eff_sub_d = sgn_a ^ sgn_b;
               exp_d     = {1'b0, (a_is_big ? exp_a : exp_b)};
               big_d     = a_is_big ? man_a : man_b;
               small_d   = a_is_big ? man_b : man_a;
               cnt_d     = shift_amt;
               if (any_special) begin
                  result_d = 32'h7FC0_0000;
                  inv_d    = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  state_d  = S_ALIGN;
               end
            end
         end

         S_ALIGN: begin
            if (cnt_q == '0) begin
               state_d = S_ADD;
            end else begin
               small_d = small_q >> 1;
               cnt_d   = cnt_q - CNT_W'(1);
            end
         end

         S_ADD: begin
            // Ordering guarantees big >= small, so the difference is never negative.
            if (eff_sub_q) begin
               mag_d = {1'b0, big_q} - {1'b0, small_q};
            end else begin
               mag_d = {1'b0, big_q} + {1'b0, small_q};
            end
            state_d = S_NORM;
         end

         S_NORM: begin
            if (mag_q == '0) begin
               result_d = 32'h0000_0000;
               state_d  = S_DONE;
            end else if (mag_q[SUM_W-1]) begin
               mag_d    = mag_q >> 1;
               exp_d    = exp_q + 9'd1;
               ovf_d    = (exp_d >= 9'd255);
               result_d = pack(sign_q, exp_d, mag_d[SUM_W-3:GUARD_BITS]);
               state_d  = S_DONE;
            end else if (mag_q[SUM_W-2]) begin
               result_d = pack(sign_q, exp_q, mag_q[SUM_W-3:GUARD_BITS]);
               state_d  = S_DONE;
            end else begin
               mag_d = mag_q << 1;
               exp_d = exp_q - 9'd1;
               if (exp_d == 9'd0) begin
                  result_d = {sign_q, 31'd0};
                  unf_d    = 1'b1;
                  state_d  = S_DONE;
               end
            end
         end

         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sign_q    <= 1'b0;
         eff_sub_q <= 1'b0;
         exp_q     <= '0;
         big_q     <= '0;
         small_q   <= '0;
         mag_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
         inv_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         eff_sub_q <= eff_sub_d;
         exp_q     <= exp_d;
         big_q     <= big_d;
         small_q   <= small_d;
         mag_q     <= mag_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
         inv_q     <= inv_d;
      end
   end

   // Handshake and status outputs decode directly from the registered state.
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      busy      = (state_q != S_IDLE);
      result    = result_q;
      flag_ovf  = ovf_q;
      flag_unf  = unf_q;
      flag_inv  = inv_q;
   end

endmodule

// File: tb/tb_fp32_add_seq_ctrl.sv
// Self-checking bench for fp32_add_seq_ctrl: directed cases plus random operands
// compared against an arithmetic reference model of the add/normalize rules.
module tb_fp32_add_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        sub = 1'b0;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic        in_ready, out_valid, flag_ovf, flag_unf, flag_inv, busy;
   logic [31:0] result;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   fp32_add_seq_ctrl #(.GUARD_BITS(2), .MAX_SHIFT(26)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag_ovf  (flag_ovf),
      .flag_unf  (flag_unf),
      .flag_inv  (flag_inv),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic expv);
      vectors++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   // Reference: exact integer arithmetic on 26-bit mantissas (1 hidden + 23 + 2 guard).
   // fl = {ovf, unf, inv}; lat = rising edges after the accepting edge until DONE.
   function automatic void ref_add(input logic [31:0] a, input logic [31:0] b,
                                   input logic s, output logic [31:0] r,
                                   output logic [2:0] fl, output int lat);
      int     ea, eb, ebig, esml, e, sh, ncyc;
      longint ma, mb, mbig, msml, m;
      logic   sa, sb, sg;
      bit     done;
      sa = a[31];
      sb = b[31] ^ s;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      ma = (ea == 0) ? 64'd0 : (longint'(a[22:0]) + 64'h80_0000) * 4;
      mb = (eb == 0) ? 64'd0 : (longint'(b[22:0]) + 64'h80_0000) * 4;
      r = 32'd0;
      fl = 3'b000;
      lat = 0;
      if (ea == 255 || eb == 255) begin
         r = 32'h7FC0_0000;
         fl = 3'b001;
         return;
      end
      if (ea > eb || (ea == eb && ma >= mb)) begin
         ebig = ea; esml = eb; mbig = ma; msml = mb; sg = sa;
      end else begin
         ebig = eb; esml = ea; mbig = mb; msml = ma; sg = sb;
      end
      sh = (ebig - esml > 26) ? 26 : (ebig - esml);
      msml = msml >> sh;
      m = (sa == sb) ? (mbig + msml) : (mbig - msml);
      e = ebig;
      ncyc = 0;
      done = 1'b0;
      while (!done) begin
         ncyc++;
         if (m == 0) begin
            r = 32'd0;
            done = 1'b1;
         end else if (m >= 64'd67108864) begin
            m = m / 2;
            e = e + 1;
            if (e >= 255) begin
               r = {sg, 8'hFF, 23'd0};
               fl = 3'b100;
            end else begin
               r = {sg, e[7:0], m[24:2]};
            end
            done = 1'b1;
         end else if (m >= 64'd33554432) begin
            r = {sg, e[7:0], m[24:2]};
            done = 1'b1;
         end else begin
            m = m * 2;
            e = e - 1;
            if (e == 0) begin
               r = {sg, 31'd0};
               fl = 3'b010;
               done = 1'b1;
            end
         end
      end
      lat = sh + 2 + ncyc;
   endfunction

   // One complete transaction: offer, wait for result, check it, then release it.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input string tag);
      logic [31:0] er;
      logic [2:0]  ef;
      int          el;
      int          cnt;
      ref_add(a, b, s, er, ef, el);
      @(negedge clk);
      op_a = a; op_b = b; sub = s; in_valid = 1'b1; out_ready = 1'b0;
      chk1({tag, "_rdy"}, in_ready, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 300) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk({tag, "_lat"}, cnt, el);
      chk({tag, "_res"}, result, er);
      chk({tag, "_flg"}, {29'd0, flag_ovf, flag_unf, flag_inv}, {29'd0, ef});
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] er, hold, ra, rb;
      logic [2:0]  ef;
      int          el, cnt, k, e1, e2;

      // Reset state
      #12;
      chk1("rst_in_ready", in_ready, 1'b1);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {29'd0, flag_ovf, flag_unf, flag_inv}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases; 1.0+1.0 expects DONE 3 edges after the accepting edge
      // (the 4th edge when the accepting edge is counted as the first).
      run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, "one_plus_one");
      chk("one_plus_one_const", result, 32'h4000_0000);
      run_op(32'h3F80_0000, 32'h3F00_0000, 1'b0, "one_plus_half");
      run_op(32'h4B80_0000, 32'h3F80_0000, 1'b0, "diff24_trunc");
      run_op(32'h3F80_0000, 32'h3F80_0000, 1'b1, "cancel_zero");
      run_op(32'h3F80_0000, 32'h3F7F_FFFF, 1'b1, "deep_norm");
      run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, "overflow");
      run_op(32'h7F80_0000, 32'h3F80_0000, 1'b0, "inf_input");
      run_op(32'h8100_0000, 32'h80FF_FFFF, 1'b1, "underflow_neg");
      run_op(32'h0000_1234, 32'h3F80_0000, 1'b0, "denorm_flush");
      run_op(32'hBF80_0000, 32'h4000_0000, 1'b0, "mixed_sign");

      // Backpressure: result held for 10 cycles, in_valid pulses ignored
      ref_add(32'h4000_0000, 32'h3F80_0000, 1'b0, er, ef, el);
      @(negedge clk);
      op_a = 32'h4000_0000; op_b = 32'h3F80_0000; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 300) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("bp_res", result, er);
      hold = er;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = i[0];
         op_a = 32'h4100_0000; op_b = 32'h4100_0000;
         @(posedge clk);
         #1;
         chk("bp_hold_res", result, hold);
         chk1("bp_hold_vld", out_valid, 1'b1);
         chk1("bp_hold_rdy", in_ready, 1'b0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk1("bp_release_vld", out_valid, 1'b0);
      chk1("bp_release_rdy", in_ready, 1'b1);

      // Reset during a 20-shift alignment
      @(negedge clk);
      op_a = 32'h4980_0000; op_b = 32'h3F80_0000; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk1("mid_busy", busy, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk1("mid_rst_vld", out_valid, 1'b0);
      chk1("mid_rst_rdy", in_ready, 1'b1);
      chk1("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_res", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'h3F80_0000, 32'h3F80_0000, 1'b0, "after_rst");

      // Random operands with exponents biased toward interesting relations
      for (int i = 0; i < 300; i++) begin
         k = $urandom_range(0, 9);
         e1 = $urandom_range(1, 254);
         case (k)
            0: e2 = 0;
            1: e2 = 255;
            2: e2 = $urandom_range(0, 255);
            3: begin e1 = 254; e2 = 254; end
            4: begin e1 = $urandom_range(1, 4); e2 = e1 - $urandom_range(0, 1); end
            default: begin
               e2 = e1 + $urandom_range(0, 6) - 3;
               if (e2 < 0) e2 = 0;
               if (e2 > 254) e2 = 254;
            end
         endcase
         ra = $urandom;
         rb = $urandom;
         ra[30:23] = e1[7:0];
         rb[30:23] = e2[7:0];
         if (k == 4 || k == 5) rb[22:0] = ra[22:0] ^ 23'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) run_op(ra, rb, 1'($urandom_range(0, 1)), "rnd_ab");
         else run_op(rb, ra, 1'($urandom_range(0, 1)), "rnd_ba");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
